// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-memory fetch controller with flush squashing
//   clk, rst            : clock, synchronous active-high reset
//   pc_curr, instr_en   : PC to fetch and fetch request from IF
//   flush               : redirect; squashes any in-flight fetch
//   mem_req, mem_addr   : request valid and registered address to memory
//   mem_gnt             : memory accepted the request
//   mem_rvalid/rdata    : memory response
//   instruction         : registered fetched word (NOP after reset/flush)
//   instr_valid         : instruction is new this cycle
//   fetch_stall         : hold the PC
module imem_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_curr,
    input  logic              instr_en,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              fetch_stall
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] RESP  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] instr_q;
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = (instr_en && !flush) ? REQ : IDLE;
            // a granted request still owes a response, so a flush then must drain it
            REQ:     state_d = mem_gnt ? (flush ? DRAIN : WAIT) : (flush ? IDLE : REQ);
            WAIT:    state_d = mem_rvalid ? (flush ? IDLE : RESP) : (flush ? DRAIN : WAIT);
            RESP:    state_d = IDLE;
            DRAIN:   state_d = mem_rvalid ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && instr_en && !flush)
                addr_q <= pc_curr;
            if (flush)
                instr_q <= NOP_INSTR;
            else if (state_q == WAIT && mem_rvalid)
                instr_q <= mem_rdata;
        end
    end
    assign mem_req     = (state_q == REQ);
    assign mem_addr    = addr_q;
    assign instruction = instr_q;
    assign instr_valid = (state_q == RESP) && !flush;
    assign fetch_stall = (state_q == IDLE) ? instr_en : (state_q != RESP);
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed and randomized checks of imem_fetch_ctrl
module tb_imem_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h0;
    logic        clk = 1'b0;
    logic        rst, instr_en, flush, mem_gnt, mem_rvalid;
    logic [31:0] pc_curr, mem_rdata;
    logic        mem_req, instr_valid, fetch_stall;
    logic [31:0] mem_addr, instruction;
    int vectors = 0;
    int errors = 0;

    imem_fetch_ctrl dut (
        .clk(clk), .rst(rst), .pc_curr(pc_curr), .instr_en(instr_en), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .instruction(instruction), .instr_valid(instr_valid),
        .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1; instr_en = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0;
        step;
        rst = 0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
        instr_en = 1; pc_curr = pc;
        step;
        mem_gnt = 1;
        step;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = data;
        step;
        mem_rvalid = 0; instr_en = 0;
        step;
    endtask

    task automatic test_reset;
        rst = 1; instr_en = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; pc_curr = 0;
        step;
        step;
        instr_en = 1;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", mem_req); end
        vectors++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
        vectors++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instruction, NOP); end
        vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", instr_valid); end
        vectors++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_en got %0b exp 1", fetch_stall); end
        instr_en = 0;
        @(negedge clk);
        vectors++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_noen got %0b exp 0", fetch_stall); end
        step;
        rst = 0;
    endtask

    task automatic test_basic;
        do_reset;
        instr_en = 1; pc_curr = 32'h10;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b0 || fetch_stall !== 1'b1) begin errors++; $display("FAIL basic_idle got req=%0b stall=%0b exp req=0 stall=1", mem_req, fetch_stall); end
        step;
        mem_gnt = 1;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL basic_req got req=%0b addr=%h exp req=1 addr=10", mem_req, mem_addr); end
        vectors++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL basic_req_stall got %0b exp 1", fetch_stall); end
        step;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b0 || fetch_stall !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL basic_wait got req=%0b stall=%0b valid=%0b exp 0 1 0", mem_req, fetch_stall, instr_valid); end
        step;
        mem_rvalid = 0;
        @(negedge clk);
        vectors++; if (instr_valid !== 1'b1 || fetch_stall !== 1'b0) begin errors++; $display("FAIL basic_resp got valid=%0b stall=%0b exp 1 0", instr_valid, fetch_stall); end
        vectors++; if (instruction !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_instr got %h exp deadbeef", instruction); end
        step;
        pc_curr = 32'h11;
        @(negedge clk);
        vectors++; if (instr_valid !== 1'b0 || fetch_stall !== 1'b1 || instruction !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_idle2 got valid=%0b stall=%0b instr=%h exp 0 1 deadbeef", instr_valid, fetch_stall, instruction); end
        step;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h11) begin errors++; $display("FAIL basic_loop got req=%0b addr=%h exp req=1 addr=11", mem_req, mem_addr); end
        step;
        do_reset;
    endtask

    task automatic test_wait_states;
        instr_en = 1; pc_curr = 32'h20;
        @(negedge clk);
        vectors++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL ws_idle_stall got %0b exp 1", fetch_stall); end
        step;
        instr_en = 0; pc_curr = 32'h99;
        for (int i = 0; i < 4; i++) begin
            mem_gnt = (i == 3);
            @(negedge clk);
            vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL ws_req%0d got req=%0b addr=%h exp req=1 addr=20", i, mem_req, mem_addr); end
            vectors++; if (fetch_stall !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL ws_req_stall%0d got stall=%0b valid=%0b exp 1 0", i, fetch_stall, instr_valid); end
            step;
        end
        mem_gnt = 0; mem_rdata = 32'hA5A50001;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = (i == 1);
            @(negedge clk);
            vectors++; if (mem_req !== 1'b0 || fetch_stall !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL ws_wait%0d got req=%0b stall=%0b valid=%0b exp 0 1 0", i, mem_req, fetch_stall, instr_valid); end
            step;
        end
        mem_rvalid = 0;
        @(negedge clk);
        vectors++; if (instr_valid !== 1'b1 || fetch_stall !== 1'b0 || instruction !== 32'hA5A50001) begin errors++; $display("FAIL ws_resp got valid=%0b stall=%0b instr=%h exp 1 0 a5a50001", instr_valid, fetch_stall, instruction); end
        step;
        @(negedge clk);
        vectors++; if (instr_valid !== 1'b0 || fetch_stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL ws_after got valid=%0b stall=%0b req=%0b exp 0 0 0", instr_valid, fetch_stall, mem_req); end
        step;
    endtask

    task automatic test_flush_wait;
        fetch(32'h25, 32'h11112222);
        instr_en = 1; pc_curr = 32'h30;
        step;
        mem_gnt = 1;
        step;
        mem_gnt = 0; flush = 1;
        @(negedge clk);
        vectors++; if (instr_valid !== 1'b0 || fetch_stall !== 1'b1) begin errors++; $display("FAIL fw_flush got valid=%0b stall=%0b exp 0 1", instr_valid, fetch_stall); end
        step;
        flush = 0; pc_curr = 32'h40;
        @(negedge clk);
        vectors++; if (fetch_stall !== 1'b1 || mem_req !== 1'b0 || instruction !== NOP) begin errors++; $display("FAIL fw_drain got stall=%0b req=%0b instr=%h exp 1 0 0", fetch_stall, mem_req, instruction); end
        step;
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        @(negedge clk);
        vectors++; if (instr_valid !== 1'b0 || fetch_stall !== 1'b1) begin errors++; $display("FAIL fw_drain_rv got valid=%0b stall=%0b exp 0 1", instr_valid, fetch_stall); end
        step;
        mem_rvalid = 0;
        @(negedge clk);
        vectors++; if (instr_valid !== 1'b0 || instruction !== NOP || fetch_stall !== 1'b1) begin errors++; $display("FAIL fw_idle got valid=%0b instr=%h stall=%0b exp 0 0 1", instr_valid, instruction, fetch_stall); end
        step;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL fw_newpc got req=%0b addr=%h exp req=1 addr=40", mem_req, mem_addr); end
        step;
        do_reset;
    endtask

    task automatic test_flush_gnt;
        do_reset;
        instr_en = 1; pc_curr = 32'h50;
        step;
        mem_gnt = 1; flush = 1;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fg_req got %0b exp 1", mem_req); end
        step;
        mem_gnt = 0; instr_en = 0;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b0 || fetch_stall !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL fg_drain got req=%0b stall=%0b valid=%0b exp 0 1 0", mem_req, fetch_stall, instr_valid); end
        step;
        flush = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        vectors++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL fg_drain2 got stall=%0b exp 1", fetch_stall); end
        step;
        mem_rvalid = 0;
        @(negedge clk);
        vectors++; if (fetch_stall !== 1'b0 || instr_valid !== 1'b0 || instruction !== NOP) begin errors++; $display("FAIL fg_idle got stall=%0b valid=%0b instr=%h exp 0 0 0", fetch_stall, instr_valid, instruction); end
        step;
    endtask

    task automatic test_flush_rvalid;
        fetch(32'h55, 32'h33334444);
        instr_en = 1; pc_curr = 32'h60;
        step;
        mem_gnt = 1;
        step;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hBADC0DE0; flush = 1;
        @(negedge clk);
        vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fr_flush got valid=%0b exp 0", instr_valid); end
        step;
        mem_rvalid = 0; flush = 0; instr_en = 0;
        @(negedge clk);
        vectors++; if (fetch_stall !== 1'b0 || mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL fr_idle got stall=%0b req=%0b valid=%0b exp 0 0 0", fetch_stall, mem_req, instr_valid); end
        vectors++; if (instruction !== NOP) begin errors++; $display("FAIL fr_instr got %h exp 0", instruction); end
        step;
    endtask

    task automatic test_idle;
        instr_en = 0;
        for (int i = 0; i < 5; i++) begin
            pc_curr = $urandom;
            @(negedge clk);
            vectors++; if (mem_req !== 1'b0 || fetch_stall !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL idle%0d got req=%0b stall=%0b valid=%0b exp 0 0 0", i, mem_req, fetch_stall, instr_valid); end
            step;
        end
    endtask

    task automatic test_rst_wait;
        fetch(32'h65, 32'h55556666);
        instr_en = 1; pc_curr = 32'h70;
        step;
        mem_gnt = 1;
        step;
        mem_gnt = 0; rst = 1;
        step;
        rst = 0; instr_en = 0;
        @(negedge clk);
        vectors++; if (fetch_stall !== 1'b0 || mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rw_idle got stall=%0b req=%0b valid=%0b exp 0 0 0", fetch_stall, mem_req, instr_valid); end
        vectors++; if (mem_addr !== 32'h0 || instruction !== NOP) begin errors++; $display("FAIL rw_regs got addr=%h instr=%h exp 0 0", mem_addr, instruction); end
        step;
        mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_stray got valid=%0b exp 0", instr_valid); end
        step;
        mem_rvalid = 0;
        @(negedge clk);
        vectors++; if (instr_valid !== 1'b0 || instruction !== NOP || fetch_stall !== 1'b0) begin errors++; $display("FAIL rw_after got valid=%0b instr=%h stall=%0b exp 0 0 0", instr_valid, instruction, fetch_stall); end
        step;
    endtask

    task automatic test_random;
        bit req_open, outstanding, squashed, deliver, n_deliver, exp_stall;
        logic [31:0] exp_addr, exp_instr;
        do_reset;
        req_open = 0; outstanding = 0; squashed = 0; deliver = 0;
        exp_addr = 0; exp_instr = NOP;
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            instr_en = ($urandom_range(0, 3) != 0);
            pc_curr = $urandom;
            flush = ($urandom_range(0, 7) == 0);
            mem_gnt = req_open && ($urandom_range(0, 2) == 0);
            mem_rvalid = outstanding ? ($urandom_range(0, 2) == 0) : (!req_open && $urandom_range(0, 9) == 0);
            mem_rdata = $urandom;
            @(negedge clk);
            exp_stall = (req_open || outstanding) ? 1'b1 : deliver ? 1'b0 : instr_en;
            vectors++; if (mem_req !== req_open) begin errors++; $display("FAIL rnd_req cyc %0d got %0b exp %0b", c, mem_req, req_open); end
            vectors++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", c, mem_addr, exp_addr); end
            vectors++; if (instruction !== exp_instr) begin errors++; $display("FAIL rnd_instr cyc %0d got %h exp %h", c, instruction, exp_instr); end
            vectors++; if (instr_valid !== (deliver && !flush)) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b exp %0b", c, instr_valid, deliver && !flush); end
            vectors++; if (fetch_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc %0d got %0b exp %0b", c, fetch_stall, exp_stall); end
            if (rst) begin
                req_open = 0; outstanding = 0; squashed = 0; deliver = 0;
                exp_addr = 0; exp_instr = NOP;
            end else begin
                n_deliver = outstanding && mem_rvalid && !squashed && !flush;
                if (flush) exp_instr = NOP;
                else if (n_deliver) exp_instr = mem_rdata;
                if (req_open) begin
                    if (mem_gnt) begin
                        req_open = 0; outstanding = 1; squashed = flush;
                    end else if (flush) req_open = 0;
                end else if (outstanding) begin
                    if (mem_rvalid) begin
                        outstanding = 0; squashed = 0;
                    end else if (flush) squashed = 1;
                end else if (!deliver && instr_en && !flush) begin
                    req_open = 1; exp_addr = pc_curr;
                end
                deliver = n_deliver;
            end
            step;
        end
        do_reset;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wait_states;
        test_flush_wait;
        test_flush_gnt;
        test_flush_rvalid;
        test_idle;
        test_rst_wait;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-memory fetch controller between the IF unit's program counter and a variable-latency instruction memory port. Turns each fetch request for the current PC into a request/grant/response transaction, registers the returned word for the IF/ID boundary, and tells the hazard logic to hold the PC until the word arrives. A branch redirect (flush) squashes any in-flight fetch so a stale instruction never reaches decode.

## Interface
- ADDR_W, 32, PC / memory word-address width (word addressed, PC increments by 1)
- DATA_W, 32, instruction width
- NOP_INSTR, 32'h00000000, value driven on `instruction` after reset/flush
- clk  input  1  sole clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- pc_curr  input  ADDR_W  PC whose instruction is wanted
- instr_en  input  1  IF requests a fetch of pc_curr
- flush  input  1  redirect taken this cycle; abort/squash current fetch
- mem_req  output  1  request valid to memory
- mem_addr  output  ADDR_W  request address (registered)
- mem_gnt  input  1  memory accepted request this cycle
- mem_rvalid  input  1  response data valid this cycle
- mem_rdata  input  DATA_W  response data
- instruction  output  DATA_W  registered fetched instruction
- instr_valid  output  1  instruction is new and valid this cycle
- fetch_stall  output  1  hold PC (to hazard unit)

## Operation
- States: IDLE, REQ, WAIT, RESP, DRAIN. Reset → IDLE.
- IDLE: if instr_en & !flush: addr_q <= pc_curr, → REQ. Else stay.
- REQ: mem_req=1, mem_addr=addr_q. mem_gnt & !flush → WAIT. flush & !mem_gnt → IDLE (request withdrawn). flush & mem_gnt → DRAIN.
- WAIT: mem_rvalid & !flush → instr_q <= mem_rdata, → RESP. flush & mem_rvalid → data discarded, → IDLE. flush & !mem_rvalid → DRAIN.
- RESP: instr_valid=1 for exactly this cycle; → IDLE unconditionally. flush in RESP: instr_valid forced 0, instruction <= NOP_INSTR.
- DRAIN: waits for the squashed response; mem_rvalid → discard, → IDLE. flush in DRAIN ignored (already squashing).
- instr_en is sampled only in IDLE; dropping it after a request is issued does not cancel it (only flush does).
- Any flush loads instruction <= NOP_INSTR the next edge; instruction otherwise holds its last value.
- fetch_stall (combinational): = instr_en in IDLE; 1 in REQ, WAIT, DRAIN; 0 in RESP.
- Memory contract: at most one outstanding request; mem_rvalid never in the same cycle as the grant; mem_rvalid outside WAIT/DRAIN is ignored.

## Timing
- Reset values: state IDLE, mem_req 0, mem_addr 0, instruction NOP_INSTR, instr_valid 0, fetch_stall = instr_en (combinational, IDLE).
- mem_req asserts the cycle after instr_en is seen in IDLE; mem_addr = pc_curr sampled at that edge.
- Zero-wait memory (gnt in first REQ cycle, rvalid next cycle): IDLE→REQ→WAIT→RESP→IDLE, 4 cycles per instruction; each gnt wait or rvalid wait adds 1 cycle.
- instruction updates at the edge leaving WAIT; instr_valid high in RESP only; PC advances at the edge ending RESP, so the next IDLE sees the new pc_curr.
- flush takes effect in the cycle asserted; mem_req drops the next cycle.
- rst mid-transaction: immediate return to IDLE, outputs to reset values; memory is reset by the same rst, so no response is pending.

## Test plan
- Reset then instr_en=1, pc_curr=0x10, gnt in first REQ cycle, rvalid next with 0xDEADBEEF → mem_addr=0x10, instruction=0xDEADBEEF, instr_valid one cycle, fetch_stall low only in RESP, 4-cycle loop.
- Memory holds gnt low 3 cycles, rvalid 2 cycles after gnt → mem_req held 4 cycles with stable mem_addr, fetch_stall continuously high, single instr_valid pulse.
- flush in WAIT before rvalid, then rvalid=0x12345678 → DRAIN entered, data discarded, instruction=NOP_INSTR, no instr_valid; next fetch uses new pc_curr.
- flush in the same cycle as mem_gnt, and separately in the same cycle as mem_rvalid → DRAIN and IDLE respectively; no instr_valid either case.
- instr_en=0 in IDLE for 5 cycles → mem_req 0, fetch_stall 0; rst asserted in WAIT → next cycle IDLE, instruction=NOP_INSTR, later stray rvalid ignored.
